mem_wb_stage: RTL



---
 rtl/riscv_pkg.sv | 32 +++
 rtl/mem_wb_stage_load_align.sv | 29 ++
 rtl/mem_wb_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory/writeback stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    WB
  } wb_state_t;

  // True when funct3 names a supported load and the address suits its size.
  function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] lane);
    logic ok;
    case (funct3)
      LB, LBU: ok = 1'b1;
      LH, LHU: ok = (lane[0] == 1'b0);
      LW:      ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane extraction and sign/zero extension
  always_comb begin
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = rdata[{addr[1], 4'b0000} +: 16];
    case (funct3)
      LB:      data = {{(XLEN-8){byte_v[7]}}, byte_v};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_v};
      LH:      data = {{(XLEN-16){half_v[15]}}, half_v};
      LHU:     data = {{(XLEN-16){1'b0}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires one instruction at a time, runs loads
// against data memory with a timeout, and drives a one-cycle regfile write.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = riscv_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_we,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_result,
  output logic            dmem_req,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  wb_state_t       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            rf_we_d, load_err_d, req_d;
  logic [4:0]      rf_wa_d;
  logic [XLEN-1:0] rf_wdata_d, addr_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] aligned;
  logic            accept, last;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dmem_rdata),
    .addr   (lane_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  assign ex_ready = (state == IDLE) || (state == WB);
  assign accept   = ex_valid && ex_ready;
  assign last     = (cnt == CW'(TIMEOUT_CYC - 1));

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rf_we_d    = 1'b0;
    load_err_d = 1'b0;
    rf_wa_d    = rf_wa;
    rf_wdata_d = rf_wdata;
    req_d      = dmem_req;
    addr_d     = dmem_addr;
    we_d       = we_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    case (state)
      IDLE, WB: begin
        state_d = IDLE;
        if (accept) begin
          we_d   = ex_we;
          rd_d   = ex_rd;
          f3_d   = ex_funct3;
          lane_d = ex_addr[1:0];
          if (!ex_is_load) begin
            state_d    = WB;
            rf_we_d    = ex_we && (ex_rd != 5'd0);
            rf_wa_d    = ex_rd;
            rf_wdata_d = ex_result;
          end else if (!load_ok(ex_funct3, ex_addr[1:0])) begin
            load_err_d = 1'b1;
          end else begin
            state_d = MEM_REQ;
            req_d   = 1'b1;
            addr_d  = {ex_addr[XLEN-1:2], 2'b00};
            cnt_d   = '0;
          end
        end
      end
      MEM_REQ: begin
        if (dmem_gnt && dmem_rvalid) begin
          req_d      = 1'b0;
          state_d    = WB;
          rf_we_d    = we_q && (rd_q != 5'd0);
          rf_wa_d    = rd_q;
          rf_wdata_d = aligned;
        end else if (dmem_gnt) begin
          // Saturate so a grant on the final budget cycle leaves MEM_WAIT
          // no further cycles before timing out.
          req_d   = 1'b0;
          state_d = MEM_WAIT;
          cnt_d   = last ? cnt : cnt + CW'(1);
        end else if (last) begin
          req_d      = 1'b0;
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid) begin
          state_d    = WB;
          rf_we_d    = we_q && (rd_q != 5'd0);
          rf_wa_d    = rd_q;
          rf_wdata_d = aligned;
        end else if (last) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, latched instruction fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wdata  <= '0;
      load_err  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_addr <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rf_we     <= rf_we_d;
      rf_wa     <= rf_wa_d;
      rf_wdata  <= rf_wdata_d;
      load_err  <= load_err_d;
      dmem_req  <= req_d;
      dmem_addr <= addr_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
    end
  end

endmodule
